core_seq_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, data-memory access and writeback around the instruction decoder, register file, ALU and PC register. It drives all datapath enables and mux selects, handshakes with the instruction and data memories, counts retired instructions and traps on illegal opcodes or a data-memory timeout.

---
 rtl/core_seq_ctrl_pkg.sv | 62 ++++++
 rtl/core_seq_ctrl_if.sv | 36 +++
 rtl/core_seq_ctrl_op_class.sv | 56 +++++
 rtl/core_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_core_seq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcode
// constants, FSM state encodings, datapath select codes and trap causes.
package core_seq_ctrl_pkg;

    localparam int OPC_W   = 7;
    localparam int STATE_W = 3;

    // RV32I base opcodes (instruction bits [6:0])
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    // FSM state encodings, also exported on state_dbg
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
    localparam logic [STATE_W-1:0] ST_TRAP   = 3'd5;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_DMEM_TO = 2'd2,
        CAUSE_RSVD    = 2'd3
    } trap_cause_e;

    // Result of classifying one opcode; wb_sel/pc_sel are the WB-state values
    typedef struct packed {
        logic    legal;
        logic    is_load;
        logic    is_store;
        logic    is_branch;
        logic    is_jump;
        logic    is_fence;
        wb_sel_e wb_sel;
        pc_sel_e pc_sel;
    } op_class_t;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and the rest of the core.
// master = the sequencer, slave = datapath and memory side.
interface core_seq_ctrl_if
    import core_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [OPC_W-1:0]   opcode;
    logic               imem_ack;
    logic               dmem_ack;
    logic               branch_taken;
    logic               imem_req;
    logic               ir_we;
    logic               dmem_req;
    logic               dmem_we;
    logic               pc_we;
    logic [1:0]         pc_sel;
    logic               rf_we;
    logic [1:0]         wb_sel;
    logic               trap;
    logic [1:0]         trap_cause;
    logic [CNT_W-1:0]   instret;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, imem_ack, dmem_ack, branch_taken,
        output imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
               rf_we, wb_sel, trap, trap_cause, instret, state_dbg
    );

    modport slave (
        output opcode, imem_ack, dmem_ack, branch_taken,
        input  imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
               rf_we, wb_sel, trap, trap_cause, instret, state_dbg
    );
endinterface

// File: rtl/core_seq_ctrl_op_class.sv
// Combinational opcode classifier feeding the sequencer.
module core_seq_ctrl_op_class
    import core_seq_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_t        cls_o
);

    // Decode opcode into legality, instruction kind and writeback/PC selects
    always_comb begin
        cls_o = '{legal: 1'b0, is_load: 1'b0, is_store: 1'b0, is_branch: 1'b0,
                  is_jump: 1'b0, is_fence: 1'b0, wb_sel: WB_ALU, pc_sel: PC_PLUS4};
        case (opcode_i)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                cls_o.legal = 1'b1;
            end
            OPC_LUI: begin
                cls_o.legal  = 1'b1;
                cls_o.wb_sel = WB_IMM;
            end
            OPC_JAL: begin
                cls_o.legal   = 1'b1;
                cls_o.is_jump = 1'b1;
                cls_o.wb_sel  = WB_PC4;
                cls_o.pc_sel  = PC_JAL;
            end
            OPC_JALR: begin
                cls_o.legal   = 1'b1;
                cls_o.is_jump = 1'b1;
                cls_o.wb_sel  = WB_PC4;
                cls_o.pc_sel  = PC_JALR;
            end
            OPC_BRANCH: begin
                cls_o.legal     = 1'b1;
                cls_o.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                cls_o.legal   = 1'b1;
                cls_o.is_load = 1'b1;
                cls_o.wb_sel  = WB_LOAD;
            end
            OPC_STORE: begin
                cls_o.legal    = 1'b1;
                cls_o.is_store = 1'b1;
            end
            OPC_FENCE: begin
                cls_o.legal    = 1'b1;
                cls_o.is_fence = 1'b1;
            end
            default: begin
                cls_o.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a terminal
// TRAP state, retired-instruction counter and data-memory timeout.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst_n,
    core_seq_ctrl_if.master  bus
);

    // Counter only needs to reach MEM_TIMEOUT-1; the cycle after that is the trap
    localparam int             TO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic               retire;
    op_class_t          cls;

    core_seq_ctrl_op_class u_op_class (
        .opcode_i (bus.opcode),
        .cls_o    (cls)
    );

    // Next-state, retirement, timeout and trap bookkeeping
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        trap_d   = trap_q;
        cause_d  = cause_q;
        retire   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls.legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (cls.is_branch) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (cls.is_load || cls.is_store) begin
                    state_d  = ST_MEM;
                    to_cnt_d = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    if (cls.is_store) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM_TO;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // Registered state, counters and sticky trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
            to_cnt_q  <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            to_cnt_q  <= to_cnt_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    // Datapath enables/selects, forced low while reset is held
    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_sel   = PC_PLUS4;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = WB_ALU;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ack;
                end
                ST_EXEC: begin
                    if (cls.is_branch) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = bus.branch_taken ? PC_BRANCH : PC_PLUS4;
                    end
                end
                ST_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = cls.is_store;
                    if (bus.dmem_ack && cls.is_store) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = PC_PLUS4;
                    end
                end
                ST_WB: begin
                    bus.pc_we  = 1'b1;
                    bus.rf_we  = cls.is_jump || !cls.is_fence;
                    bus.wb_sel = cls.wb_sel;
                    bus.pc_sel = cls.pc_sel;
                end
                default: begin
                    bus.imem_req = 1'b0;
                end
            endcase
        end
    end

    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.instret    = instret_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed testbench for core_seq_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_core_seq_ctrl;
    import core_seq_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    core_seq_ctrl_if #(.CNT_W(4)) bus ();

    core_seq_ctrl #(
        .CNT_W       (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic ia,
                                 input logic da, input logic bt);
        bus.opcode       = op;
        bus.imem_ack     = ia;
        bus.dmem_ack     = da;
        bus.branch_taken = bt;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed sequence; comments give the state the DUT is in
    initial begin
        rst_n = 1'b0;
        bus.opcode = OPC_OP_IMM;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.branch_taken = 1'b0;
        #12;
        checkOutput("rst_imem_req", 32'(bus.imem_req), 0);
        checkOutput("rst_pc_we", 32'(bus.pc_we), 0);
        checkOutput("rst_state", 32'(bus.state_dbg), 0);
        checkOutput("rst_instret", 32'(bus.instret), 0);
        checkOutput("rst_trap", 32'(bus.trap), 0);

        // ADDI, zero-wait fetch
        nextCycle(); rst_n = 1'b1;
        applyStimulus(OPC_OP_IMM, 1, 0, 0);                 // FETCH
        checkOutput("addi_imem_req", 32'(bus.imem_req), 1);
        checkOutput("addi_ir_we", 32'(bus.ir_we), 1);
        nextCycle(); applyStimulus(OPC_OP_IMM, 1, 0, 0);    // DECODE
        checkOutput("addi_decode", 32'(bus.state_dbg), 1);
        nextCycle(); applyStimulus(OPC_OP_IMM, 1, 0, 0);    // EXEC
        checkOutput("addi_exec", 32'(bus.state_dbg), 2);
        checkOutput("addi_exec_rf_we", 32'(bus.rf_we), 0);
        nextCycle(); applyStimulus(OPC_OP_IMM, 1, 0, 0);    // WB
        checkOutput("addi_wb_rf_we", 32'(bus.rf_we), 1);
        checkOutput("addi_wb_pc_we", 32'(bus.pc_we), 1);
        checkOutput("addi_wb_sel", 32'(bus.wb_sel), 0);

        // BEQ taken then not taken
        nextCycle(); applyStimulus(OPC_BRANCH, 1, 0, 1);    // FETCH
        checkOutput("addi_instret", 32'(bus.instret), 1);
        nextCycle(); applyStimulus(OPC_BRANCH, 1, 0, 1);    // DECODE
        nextCycle(); applyStimulus(OPC_BRANCH, 1, 0, 1);    // EXEC
        checkOutput("beq_t_pc_we", 32'(bus.pc_we), 1);
        checkOutput("beq_t_pc_sel", 32'(bus.pc_sel), 1);
        checkOutput("beq_t_rf_we", 32'(bus.rf_we), 0);
        nextCycle(); applyStimulus(OPC_BRANCH, 1, 0, 0);    // FETCH
        checkOutput("beq_t_instret", 32'(bus.instret), 2);
        nextCycle(); applyStimulus(OPC_BRANCH, 1, 0, 0);    // DECODE
        nextCycle(); applyStimulus(OPC_BRANCH, 1, 0, 0);    // EXEC
        checkOutput("beq_nt_pc_we", 32'(bus.pc_we), 1);
        checkOutput("beq_nt_pc_sel", 32'(bus.pc_sel), 0);
        checkOutput("beq_nt_rf_we", 32'(bus.rf_we), 0);

        // LW, ack on the 4th MEM cycle (same cycle the timeout would fire)
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // FETCH
        checkOutput("beq_nt_instret", 32'(bus.instret), 3);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // DECODE
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // EXEC
        checkOutput("lw_exec_dmem_req", 32'(bus.dmem_req), 0);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // MEM 1
        checkOutput("lw_mem1_dmem_req", 32'(bus.dmem_req), 1);
        checkOutput("lw_mem1_dmem_we", 32'(bus.dmem_we), 0);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // MEM 2
        checkOutput("lw_mem2_dmem_req", 32'(bus.dmem_req), 1);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // MEM 3
        checkOutput("lw_mem3_dmem_req", 32'(bus.dmem_req), 1);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 1, 0);      // MEM 4, ack
        checkOutput("lw_mem4_dmem_req", 32'(bus.dmem_req), 1);
        checkOutput("lw_mem4_rf_we", 32'(bus.rf_we), 0);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // WB
        checkOutput("lw_wb_state", 32'(bus.state_dbg), 4);
        checkOutput("lw_wb_no_trap", 32'(bus.trap), 0);
        checkOutput("lw_wb_sel", 32'(bus.wb_sel), 1);
        checkOutput("lw_wb_rf_we", 32'(bus.rf_we), 1);
        checkOutput("lw_wb_dmem_req", 32'(bus.dmem_req), 0);

        // JAL
        nextCycle(); applyStimulus(OPC_JAL, 1, 0, 0);       // FETCH
        checkOutput("lw_instret", 32'(bus.instret), 4);
        nextCycle(); nextCycle(); nextCycle(); #1;          // WB
        checkOutput("jal_wb_sel", 32'(bus.wb_sel), 2);
        checkOutput("jal_pc_sel", 32'(bus.pc_sel), 2);
        checkOutput("jal_rf_we", 32'(bus.rf_we), 1);

        // LUI
        nextCycle(); applyStimulus(OPC_LUI, 1, 0, 0);       // FETCH
        checkOutput("jal_instret", 32'(bus.instret), 5);
        nextCycle(); nextCycle(); nextCycle(); #1;          // WB
        checkOutput("lui_wb_sel", 32'(bus.wb_sel), 3);
        checkOutput("lui_pc_sel", 32'(bus.pc_sel), 0);

        // JALR
        nextCycle(); applyStimulus(OPC_JALR, 1, 0, 0);      // FETCH
        nextCycle(); nextCycle(); nextCycle(); #1;          // WB
        checkOutput("jalr_wb_sel", 32'(bus.wb_sel), 2);
        checkOutput("jalr_pc_sel", 32'(bus.pc_sel), 3);

        // FENCE behaves as a NOP
        nextCycle(); applyStimulus(OPC_FENCE, 1, 0, 0);     // FETCH
        checkOutput("jalr_instret", 32'(bus.instret), 7);
        nextCycle(); nextCycle(); nextCycle(); #1;          // WB
        checkOutput("fence_rf_we", 32'(bus.rf_we), 0);
        checkOutput("fence_pc_we", 32'(bus.pc_we), 1);

        // SW with zero-wait data memory
        nextCycle(); applyStimulus(OPC_STORE, 1, 1, 0);     // FETCH
        checkOutput("fence_instret", 32'(bus.instret), 8);
        nextCycle(); nextCycle(); nextCycle(); #1;          // MEM
        checkOutput("sw_dmem_req", 32'(bus.dmem_req), 1);
        checkOutput("sw_dmem_we", 32'(bus.dmem_we), 1);
        checkOutput("sw_pc_we", 32'(bus.pc_we), 1);
        checkOutput("sw_pc_sel", 32'(bus.pc_sel), 0);
        checkOutput("sw_rf_we", 32'(bus.rf_we), 0);

        // Seven ADDIs take instret from 9 through 16, which wraps to 0
        nextCycle(); #1;                                    // FETCH
        checkOutput("sw_instret", 32'(bus.instret), 9);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(OPC_OP_IMM, 1, 0, 0);
            repeat (4) nextCycle();
        end
        #1;
        checkOutput("wrap_instret", 32'(bus.instret), 0);
        checkOutput("wrap_state", 32'(bus.state_dbg), 0);

        // SW that never gets an ack -> timeout trap after 4 MEM cycles
        applyStimulus(OPC_STORE, 1, 0, 0);                  // FETCH
        nextCycle(); nextCycle(); nextCycle(); #1;          // MEM 1
        checkOutput("to_mem1_dmem_req", 32'(bus.dmem_req), 1);
        checkOutput("to_mem1_dmem_we", 32'(bus.dmem_we), 1);
        nextCycle(); nextCycle(); nextCycle(); #1;          // MEM 4
        checkOutput("to_mem4_dmem_req", 32'(bus.dmem_req), 1);
        checkOutput("to_mem4_trap", 32'(bus.trap), 0);
        nextCycle(); #1;                                    // TRAP
        checkOutput("to_trap", 32'(bus.trap), 1);
        checkOutput("to_cause", 32'(bus.trap_cause), 2);
        checkOutput("to_dmem_req", 32'(bus.dmem_req), 0);
        checkOutput("to_state", 32'(bus.state_dbg), 5);
        checkOutput("to_instret", 32'(bus.instret), 0);
        nextCycle(); applyStimulus(OPC_OP_IMM, 1, 1, 0);    // still TRAP
        checkOutput("to_hold_state", 32'(bus.state_dbg), 5);
        checkOutput("to_hold_pc_we", 32'(bus.pc_we), 0);
        checkOutput("to_hold_imem_req", 32'(bus.imem_req), 0);

        // Async reset clears the trap immediately
        rst_n = 1'b0; #1;
        checkOutput("rst2_trap", 32'(bus.trap), 0);
        checkOutput("rst2_cause", 32'(bus.trap_cause), 0);
        checkOutput("rst2_state", 32'(bus.state_dbg), 0);

        // SYSTEM opcode -> illegal-instruction trap after DECODE
        nextCycle(); rst_n = 1'b1;
        applyStimulus(OPC_SYSTEM, 1, 0, 0);                 // FETCH
        checkOutput("sys_imem_req", 32'(bus.imem_req), 1);
        nextCycle(); #1;                                    // DECODE
        checkOutput("sys_dec_pc_we", 32'(bus.pc_we), 0);
        checkOutput("sys_dec_rf_we", 32'(bus.rf_we), 0);
        nextCycle(); #1;                                    // TRAP
        checkOutput("sys_trap", 32'(bus.trap), 1);
        checkOutput("sys_cause", 32'(bus.trap_cause), 1);
        checkOutput("sys_pc_we", 32'(bus.pc_we), 0);
        checkOutput("sys_rf_we", 32'(bus.rf_we), 0);
        checkOutput("sys_instret", 32'(bus.instret), 0);

        // Fetch wait state, then reset asserted in the middle of MEM
        rst_n = 1'b0;
        nextCycle(); rst_n = 1'b1;
        applyStimulus(OPC_LOAD, 0, 0, 0);                   // FETCH, no ack
        checkOutput("wait_imem_req", 32'(bus.imem_req), 1);
        checkOutput("wait_ir_we", 32'(bus.ir_we), 0);
        nextCycle(); applyStimulus(OPC_LOAD, 1, 0, 0);      // still FETCH
        checkOutput("wait_state", 32'(bus.state_dbg), 0);
        checkOutput("wait_ir_we_ack", 32'(bus.ir_we), 1);
        nextCycle(); nextCycle(); nextCycle(); #1;          // MEM
        checkOutput("abort_pre_dmem_req", 32'(bus.dmem_req), 1);
        rst_n = 1'b0; #1;
        checkOutput("abort_dmem_req", 32'(bus.dmem_req), 0);
        checkOutput("abort_imem_req", 32'(bus.imem_req), 0);
        checkOutput("abort_state", 32'(bus.state_dbg), 0);
        nextCycle();
        checkOutput("abort_hold_dmem_req", 32'(bus.dmem_req), 0);
        checkOutput("abort_hold_instret", 32'(bus.instret), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
